// File: rtl/vec_pkg.sv
// Shared types for the vector operand loader: element/opcode widths and the
// load sequencer state encoding.
package vec_pkg;

    localparam int ELEM_W = 32;
    localparam int OPC_W  = 8;

    typedef logic [ELEM_W-1:0] elem_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ISSUE,
        WAIT
    } load_state_t;

endpackage

// File: rtl/vector_bank.sv
// One packed operand bank of MAX_N elements, written one element per cycle
// by index and cleared either by reset or by a synchronous clear.
module vector_bank
    import vec_pkg::*;
#(
    parameter int MAX_N = 128,
    parameter int IDX_W = $clog2(MAX_N + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  elem_t                   wr_data,
    output elem_t [MAX_N-1:0]       vec
);

    logic [MAX_N-1:0] hit;

    generate
        for (genvar gi = 0; gi < MAX_N; gi++) begin : g_hit
            assign hit[gi] = wr_en && (wr_idx == IDX_W'(gi));
        end
    endgenerate

    // Clear wins over a same-cycle write; the loader never does both at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec <= '0;
        end else if (clr) begin
            vec <= '0;
        end else begin
            for (int i = 0; i < MAX_N; i++) begin
                if (hit[i]) begin
                    vec[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/vector_operand_loader.sv
// Command + element-stream front end for the vector core: latches a command,
// fills operand banks A then B, strobes start and waits for the core's done.
module vector_operand_loader
    import vec_pkg::*;
#(
    parameter int MAX_N = 128,
    parameter int IDX_W = $clog2(MAX_N + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPC_W-1:0]        cmd_opcode,
    input  logic [31:0]             cmd_n,
    output logic                    cmd_err,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ELEM_W-1:0]       in_data,
    output logic [OPC_W-1:0]        vec_opcode,
    output logic [31:0]             vec_n,
    output elem_t [MAX_N-1:0]       vec_a,
    output elem_t [MAX_N-1:0]       vec_b,
    output logic                    vec_start,
    input  logic                    core_done,
    output logic                    busy
);

    load_state_t        state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [IDX_W-1:0]   n_eff_reg;
    logic [OPC_W-1:0]   opcode_reg;
    logic               start_reg;

    logic               accept;
    logic               over;
    logic [IDX_W-1:0]   n_in;
    logic               last;
    logic               wr_a;
    logic               wr_b;

    assign accept = (state_reg == IDLE) && cmd_valid;
    assign over   = cmd_n > 32'(MAX_N);
    assign n_in   = over ? IDX_W'(MAX_N) : cmd_n[IDX_W-1:0];
    assign last   = idx_reg == (n_eff_reg - IDX_W'(1));
    assign wr_a   = (state_reg == LOAD_A) && in_valid;
    assign wr_b   = (state_reg == LOAD_B) && in_valid;

    assign cmd_ready  = state_reg == IDLE;
    assign in_ready   = (state_reg == LOAD_A) || (state_reg == LOAD_B);
    assign busy       = state_reg != IDLE;
    // Error flags the accepting cycle itself, so it is decoded, not registered.
    assign cmd_err    = !rst && accept && over;
    assign vec_start  = start_reg;
    assign vec_opcode = opcode_reg;
    assign vec_n      = 32'(n_eff_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            n_eff_reg  <= '0;
            opcode_reg <= '0;
            start_reg  <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        opcode_reg <= cmd_opcode;
                        n_eff_reg  <= n_in;
                        idx_reg    <= '0;
                        if (n_in == '0) begin
                            state_reg <= ISSUE;
                            start_reg <= 1'b1;
                        end else begin
                            state_reg <= LOAD_A;
                        end
                    end
                end
                LOAD_A: begin
                    if (in_valid) begin
                        if (last) begin
                            idx_reg   <= '0;
                            state_reg <= LOAD_B;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        if (last) begin
                            idx_reg   <= '0;
                            state_reg <= ISSUE;
                            start_reg <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    vector_bank #(.MAX_N(MAX_N), .IDX_W(IDX_W)) u_bank_a (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .wr_en   (wr_a),
        .wr_idx  (idx_reg),
        .wr_data (in_data),
        .vec     (vec_a)
    );

    vector_bank #(.MAX_N(MAX_N), .IDX_W(IDX_W)) u_bank_b (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .wr_en   (wr_b),
        .wr_idx  (idx_reg),
        .wr_data (in_data),
        .vec     (vec_b)
    );

endmodule

// File: tb/tb_vector_operand_loader.sv
// Randomized bench for vector_operand_loader against a simple stream model:
// operands are whatever the bench streamed, start lands after 2*n_eff+1+stalls.
module tb_vector_operand_loader;

    localparam int MAX_N = 128;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [7:0]              cmd_opcode;
    logic [31:0]             cmd_n;
    logic                    cmd_err;
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             in_data;
    logic [7:0]              vec_opcode;
    logic [31:0]             vec_n;
    logic [MAX_N-1:0][31:0]  vec_a;
    logic [MAX_N-1:0][31:0]  vec_b;
    logic                    vec_start;
    logic                    core_done;
    logic                    busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] stim_a [MAX_N];
    logic [31:0] stim_b [MAX_N];

    int r_start, r_consumed, r_err, r_starts, r_stalls;

    vector_operand_loader #(.MAX_N(MAX_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_n      (cmd_n),
        .cmd_err    (cmd_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .vec_opcode (vec_opcode),
        .vec_n      (vec_n),
        .vec_a      (vec_a),
        .vec_b      (vec_b),
        .vec_start  (vec_start),
        .core_done  (core_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model: entry i holds the i-th streamed element below n_eff, zero above.
    function automatic int diff_a(input int ne);
        int d = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec_a[i] !== ((i < ne) ? stim_a[i] : 32'd0)) d++;
        end
        return d;
    endfunction

    function automatic int diff_b(input int ne);
        int d = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec_b[i] !== ((i < ne) ? stim_b[i] : 32'd0)) d++;
        end
        return d;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < MAX_N; i++) begin
            stim_a[i] = $urandom;
            stim_b[i] = $urandom;
        end
    endtask

    // Drives one command plus its element stream; mode 0 = always valid,
    // 1 = valid toggling 1,0,1,..., otherwise valid 3 cycles out of 4 on average.
    task automatic do_cmd(input logic [7:0] opc, input logic [31:0] n,
                          input int mode, input bit hold_done);
        int  ne;
        int  ptr;
        int  budget;
        bit  v;
        ne = (n > MAX_N) ? MAX_N : int'(n);
        r_start = -1; r_consumed = 0; r_err = 0; r_starts = 0; r_stalls = 0;
        ptr = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = opc; cmd_n = n;
        in_valid = 1'b0; core_done = hold_done;
        #1;
        if (cmd_err) r_err++;
        budget = 4 * ne + 20;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 1;
                default: v = $urandom_range(0, 3) != 0;
            endcase
            in_valid  = v;
            in_data   = (ptr < ne) ? stim_a[ptr] : (ptr < 2 * ne) ? stim_b[ptr - ne] : $urandom;
            core_done = (ptr < ne) ? hold_done : 1'b0;
            if (!v && ptr < 2 * ne) r_stalls++;
            #1;
            if (cmd_err) r_err++;
            if (vec_start) begin
                r_starts++;
                if (r_start < 0) r_start = cyc;
            end
            if (in_valid && in_ready) begin
                r_consumed++;
                ptr++;
            end
            if (r_start >= 0 && cyc >= r_start + 2) break;
        end
        in_valid = 1'b0;
        core_done = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b0 || vec_start !== 1'b0 || cmd_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b cmd_ready=%b in_ready=%b start=%b err=%b, required 0 1 0 0 0",
                     busy, cmd_ready, in_ready, vec_start, cmd_err);
        end
        total++;
        if (vec_opcode !== 8'd0 || vec_n !== 32'd0 || diff_a(0) != 0 || diff_b(0) != 0) begin
            bad++;
            $display("FAIL reset_data: opcode=%h n=%0d a_diff=%0d b_diff=%0d, required all zero",
                     vec_opcode, vec_n, diff_a(0), diff_b(0));
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: busy=%b cmd_ready=%b", busy, cmd_ready);
    endtask

    task automatic test_basic();
        fill_random();
        stim_a[0] = 1;  stim_a[1] = 2;  stim_a[2] = 3;
        stim_b[0] = 10; stim_b[1] = 20; stim_b[2] = 30;
        do_cmd(8'h01, 32'd3, 0, 1'b0);
        total++;
        if (r_start != 7 || r_starts != 1) begin
            bad++;
            $display("FAIL basic_start: cycle=%0d pulses=%0d, required cycle 7 pulses 1", r_start, r_starts);
        end
        total++;
        if (r_consumed != 6 || r_err != 0) begin
            bad++;
            $display("FAIL basic_consume: consumed=%0d err=%0d, required 6 and 0", r_consumed, r_err);
        end
        total++;
        if (diff_a(3) != 0 || diff_b(3) != 0 || vec_opcode !== 8'h01 || vec_n !== 32'd3) begin
            bad++;
            $display("FAIL basic_data: a_diff=%0d b_diff=%0d opcode=%h n=%0d, required 0 0 01 3",
                     diff_a(3), diff_b(3), vec_opcode, vec_n);
        end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_wait: busy=%b cmd_ready=%b, required 1 0", busy, cmd_ready);
        end
        pulse_done();
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || diff_a(3) != 0) begin
            bad++;
            $display("FAIL basic_done: busy=%b cmd_ready=%b a_diff=%0d, required 0 1 0", busy, cmd_ready, diff_a(3));
        end
        $display("basic: n=3 start=%0d consumed=%0d", r_start, r_consumed);
    endtask

    task automatic test_stall();
        fill_random();
        do_cmd(8'h22, 32'd2, 1, 1'b0);
        total++;
        if (r_start != 2 * 2 + 1 + r_stalls || r_start != 8) begin
            bad++;
            $display("FAIL stall_start: cycle=%0d stalls=%0d, required %0d", r_start, r_stalls, 5 + r_stalls);
        end
        total++;
        if (r_consumed != 4 || diff_a(2) != 0 || diff_b(2) != 0) begin
            bad++;
            $display("FAIL stall_data: consumed=%0d a_diff=%0d b_diff=%0d, required 4 0 0",
                     r_consumed, diff_a(2), diff_b(2));
        end
        pulse_done();
        $display("stall: n=2 start=%0d stalls=%0d", r_start, r_stalls);
    endtask

    task automatic test_clamp();
        fill_random();
        do_cmd(8'h33, 32'd200, 3, 1'b0);
        total++;
        if (r_err != 1 || vec_n !== 32'd128) begin
            bad++;
            $display("FAIL clamp_err: err_pulses=%0d vec_n=%0d, required 1 and 128", r_err, vec_n);
        end
        total++;
        if (r_consumed != 256 || r_start != 2 * MAX_N + 1 + r_stalls || r_starts != 1) begin
            bad++;
            $display("FAIL clamp_stream: consumed=%0d start=%0d pulses=%0d, required 256 %0d 1",
                     r_consumed, r_start, r_starts, 2 * MAX_N + 1 + r_stalls);
        end
        total++;
        if (diff_a(MAX_N) != 0 || diff_b(MAX_N) != 0) begin
            bad++;
            $display("FAIL clamp_data: a_diff=%0d b_diff=%0d, required 0 0", diff_a(MAX_N), diff_b(MAX_N));
        end
        pulse_done();
        $display("clamp: n=200 vec_n=%0d consumed=%0d", vec_n, r_consumed);
    endtask

    task automatic test_zero();
        do_cmd(8'h44, 32'd0, 0, 1'b0);
        total++;
        if (r_start != 1 || r_consumed != 0 || r_starts != 1) begin
            bad++;
            $display("FAIL zero_start: cycle=%0d consumed=%0d pulses=%0d, required 1 0 1",
                     r_start, r_consumed, r_starts);
        end
        total++;
        if (diff_a(0) != 0 || diff_b(0) != 0 || vec_n !== 32'd0 || vec_opcode !== 8'h44) begin
            bad++;
            $display("FAIL zero_data: a_diff=%0d b_diff=%0d n=%0d opcode=%h, required 0 0 0 44",
                     diff_a(0), diff_b(0), vec_n, vec_opcode);
        end
        pulse_done();
        $display("zero: start=%0d consumed=%0d", r_start, r_consumed);
    endtask

    task automatic test_reset_mid();
        fill_random();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 8'h55; cmd_n = 32'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            in_valid  = 1'b1;
            in_data   = (k < 3) ? stim_a[k] : stim_b[0];
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b0 || vec_opcode !== 8'd0 || vec_n !== 32'd0
            || diff_a(0) != 0 || diff_b(0) != 0) begin
            bad++;
            $display("FAIL midreset: busy=%b ready=%b in_ready=%b opc=%h n=%0d a_diff=%0d b_diff=%0d, required cleared",
                     busy, cmd_ready, in_ready, vec_opcode, vec_n, diff_a(0), diff_b(0));
        end
        @(negedge clk);
        rst = 1'b0;
        fill_random();
        do_cmd(8'h66, 32'd1, 0, 1'b0);
        total++;
        if (r_start != 3 || diff_a(1) != 0 || diff_b(1) != 0 || vec_opcode !== 8'h66) begin
            bad++;
            $display("FAIL midreset_reload: start=%0d a_diff=%0d b_diff=%0d opc=%h, required 3 0 0 66",
                     r_start, diff_a(1), diff_b(1), vec_opcode);
        end
        pulse_done();
        $display("reset_mid: reload start=%0d", r_start);
    endtask

    task automatic test_done_and_held_cmd();
        fill_random();
        do_cmd(8'h77, 32'd4, 3, 1'b1);
        total++;
        if (r_start != 9 + r_stalls || diff_a(4) != 0 || diff_b(4) != 0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL done_ignored: start=%0d a_diff=%0d b_diff=%0d busy=%b, required %0d 0 0 1",
                     r_start, diff_a(4), diff_b(4), busy, 9 + r_stalls);
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 8'h88; cmd_n = 32'd5;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b0 || vec_opcode !== 8'h77 || vec_n !== 32'd4) begin
            bad++;
            $display("FAIL held_cmd: cmd_ready=%b opc=%h n=%0d, required 0 77 4", cmd_ready, vec_opcode, vec_n);
        end
        @(negedge clk);
        core_done = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL held_cmd_waitexit: cmd_ready=%b, required 0", cmd_ready);
        end
        @(negedge clk);
        core_done = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL held_cmd_idle: cmd_ready=%b, required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        total++;
        if (vec_opcode !== 8'h88 || vec_n !== 32'd5 || diff_a(0) != 0 || diff_b(0) != 0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL held_cmd_accept: opc=%h n=%0d a_diff=%0d b_diff=%0d in_ready=%b, required 88 5 0 0 1",
                     vec_opcode, vec_n, diff_a(0), diff_b(0), in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("done_held: start=%0d second opc=%h", r_start, vec_opcode);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 4; t++) begin
            logic [7:0] opc;
            int n;
            opc = 8'($urandom);
            n   = $urandom_range(1, 20);
            fill_random();
            do_cmd(opc, 32'(n), 3, 1'b0);
            total++;
            if (r_start != 2 * n + 1 + r_stalls || r_consumed != 2 * n || r_starts != 1) begin
                bad++;
                $display("FAIL b2b_timing[%0d]: start=%0d consumed=%0d pulses=%0d, required %0d %0d 1",
                         t, r_start, r_consumed, r_starts, 2 * n + 1 + r_stalls, 2 * n);
            end
            total++;
            if (diff_a(n) != 0 || diff_b(n) != 0 || vec_opcode !== opc || vec_n !== 32'(n)) begin
                bad++;
                $display("FAIL b2b_data[%0d]: a_diff=%0d b_diff=%0d opc=%h n=%0d, required 0 0 %h %0d",
                         t, diff_a(n), diff_b(n), vec_opcode, vec_n, opc, n);
            end
            pulse_done();
            $display("b2b[%0d]: n=%0d start=%0d stalls=%0d", t, n, r_start, r_stalls);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_opcode = '0; cmd_n = '0;
        in_valid = 1'b0; in_data = '0; core_done = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_clamp();
        test_zero();
        test_reset_mid();
        test_done_and_held_cmd();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
